switch_case_seq: RTL and testbench

SWITCH_CASE_SEQ -- requirements
Module: switch_case_seq

---
 rtl/switch_case_seq_if.sv | 60 ++++++
 rtl/switch_case_seq.sv | 129 ++++++++++++
 tb/tb_switch_case_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_case_seq_if.sv
// switch_case_seq_if -- control, configuration and status bundle for switch_case_seq.
//
// Optional feature: define SWITCH_CASE_SEQ_ABORT_EN to add the abort input.
//
// Signals (master drives inputs of the sequencer, slave is the sequencer):
//   start     begin a sequence (honoured only while idle)
//   mode      0 = one-shot, 1 = loop (sampled at each wrap point)
//   hold      freeze position and dwell counter while running
//   cfg_we    table write strobe (honoured only while idle)
//   cfg_addr  table entry index
//   cfg_out   output value for the entry
//   cfg_dwell dwell for the entry; the entry lasts dwell+1 cycles
//   abort     (optional) end a running sequence at once, no done pulse
//   out       decoded output of the current entry
//   out_num   registered copy of the entry index
//   busy      high while running
//   done      one-cycle completion pulse after a one-shot run
interface switch_case_seq_if #(
    parameter int unsigned STATES  = 4,
    parameter int unsigned OUT_W   = 2,
    parameter int unsigned NUM_W   = 3,
    parameter int unsigned DWELL_W = 4
);
    localparam int unsigned SW = $clog2(STATES);

    logic               start;
    logic               mode;
    logic               hold;
    logic               cfg_we;
    logic [SW-1:0]      cfg_addr;
    logic [OUT_W-1:0]   cfg_out;
    logic [DWELL_W-1:0] cfg_dwell;
`ifdef SWITCH_CASE_SEQ_ABORT_EN
    logic               abort;
`endif
    logic [OUT_W-1:0]   out;
    logic [NUM_W-1:0]   out_num;
    logic               busy;
    logic               done;

`ifdef SWITCH_CASE_SEQ_ABORT_EN
    modport master (
        output start, mode, hold, cfg_we, cfg_addr, cfg_out, cfg_dwell, abort,
        input  out, out_num, busy, done
    );
    modport slave (
        input  start, mode, hold, cfg_we, cfg_addr, cfg_out, cfg_dwell, abort,
        output out, out_num, busy, done
    );
`else
    modport master (
        output start, mode, hold, cfg_we, cfg_addr, cfg_out, cfg_dwell,
        input  out, out_num, busy, done
    );
    modport slave (
        input  start, mode, hold, cfg_we, cfg_addr, cfg_out, cfg_dwell,
        output out, out_num, busy, done
    );
`endif
endinterface

// File: rtl/switch_case_seq.sv
// switch_case_seq -- table-driven output sequencer.
//
// A programmable table of STATES entries (output value + dwell) is stepped
// through once (one-shot) or repeatedly (loop). Each entry is presented for
// dwell+1 cycles unless hold freezes the sequence.
//
// Optional feature: define SWITCH_CASE_SEQ_ABORT_EN to add bus.abort, which
// ends a running sequence on the next cycle without a done pulse.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset (also clears the table)
//   bus    switch_case_seq_if.slave: start/mode/hold/cfg_* in,
//          out/out_num/busy/done out
module switch_case_seq #(
    parameter int unsigned STATES  = 4,
    parameter int unsigned OUT_W   = 2,
    parameter int unsigned NUM_W   = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    switch_case_seq_if.slave  bus
);
    localparam int unsigned   SW   = $clog2(STATES);
    localparam logic [SW-1:0] LAST = SW'(STATES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic [SW-1:0]      idx_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [NUM_W-1:0]   out_num_q;
    logic               done_q;
    logic [OUT_W-1:0]   tbl_out_q   [STATES];
    logic [DWELL_W-1:0] tbl_dwell_q [STATES];

    logic [SW-1:0]      idx_inc;
    logic [DWELL_W-1:0] first_dwell;
    logic               abort_req;

    assign idx_inc = idx_q + 1'b1;

    // A write to entry 0 in the same cycle as start must be seen by the first load.
    assign first_dwell = (bus.cfg_we && (bus.cfg_addr == '0)) ? bus.cfg_dwell : tbl_dwell_q[0];

`ifdef SWITCH_CASE_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            out_num_q <= '0;
            done_q    <= 1'b0;
            for (int unsigned i = 0; i < STATES; i++) begin
                tbl_out_q[i]   <= '0;
                tbl_dwell_q[i] <= '0;
            end
        end else begin
            done_q    <= 1'b0;
            out_num_q <= NUM_W'(idx_q);

            case (state_q)
                StIdle: begin
                    // out_num reads 0 while idle, including the first run cycle.
                    out_num_q <= '0;
                    idx_q     <= '0;
                    if (bus.cfg_we) begin
                        tbl_out_q[bus.cfg_addr]   <= bus.cfg_out;
                        tbl_dwell_q[bus.cfg_addr] <= bus.cfg_dwell;
                    end
                    if (bus.start) begin
                        state_q <= StRun;
                        cnt_q   <= first_dwell;
                    end
                end
                StRun: begin
                    if (abort_req) begin
                        state_q   <= StIdle;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        out_num_q <= '0;
                    end else if (bus.hold) begin
                        // Frozen: idx and cnt keep their values.
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (idx_q != LAST) begin
                        idx_q <= idx_inc;
                        cnt_q <= tbl_dwell_q[idx_inc];
                    end else if (bus.mode) begin
                        idx_q <= '0;
                        cnt_q <= tbl_dwell_q[0];
                    end else begin
                        state_q   <= StIdle;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        out_num_q <= '0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    idx_q     <= '0;
                    cnt_q     <= '0;
                    out_num_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.out = '0;
        case (state_q)
            StIdle:  bus.out = '0;
            StRun:   bus.out = tbl_out_q[idx_q];
            default: bus.out = '0;
        endcase
    end

    assign bus.out_num = out_num_q;
    assign bus.busy    = (state_q == StRun);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_switch_case_seq.sv
// Directed self-checking bench for switch_case_seq (default parameters).
module tb_switch_case_seq;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   chk_cnt;

    switch_case_seq_if #(.STATES(4), .OUT_W(2), .NUM_W(3), .DWELL_W(4)) bus ();

    switch_case_seq #(.STATES(4), .OUT_W(2), .NUM_W(3), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int addr, input int o, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'(addr);
        bus.cfg_out   = 2'(o);
        bus.cfg_dwell = 4'(d);
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic prog_default();
        prog(0, 1, 0);
        prog(1, 3, 1);
        prog(2, 2, 0);
        prog(3, 0, 2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        chk_cnt++;
        if (bus.out !== 2'd0) $display("FAIL reset_out: got %0d want 0", bus.out);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_num !== 3'd0) $display("FAIL reset_out_num: got %0d want 0", bus.out_num);
        else pass_cnt++;
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
        else pass_cnt++;
        chk_cnt++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_one_shot();
        int exp_out [7];
        int exp_num [7];
        exp_out = '{1, 3, 3, 2, 0, 0, 0};
        exp_num = '{0, 0, 1, 1, 2, 3, 3};
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk_cnt++;
            if (bus.out !== 2'(exp_out[i]) || bus.busy !== 1'b1 || bus.done !== 1'b0)
                $display("FAIL one_shot_c%0d: out=%0d busy=%b done=%b want out=%0d busy=1 done=0",
                         i + 1, bus.out, bus.busy, bus.done, exp_out[i]);
            else pass_cnt++;
            chk_cnt++;
            if (bus.out_num !== 3'(exp_num[i]))
                $display("FAIL one_shot_num_c%0d: got %0d want %0d", i + 1, bus.out_num, exp_num[i]);
            else pass_cnt++;
            step();
        end
        chk_cnt++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 2'd0 || bus.out_num !== 3'd0)
            $display("FAIL one_shot_end: done=%b busy=%b out=%0d num=%0d want 1 0 0 0",
                     bus.done, bus.busy, bus.out, bus.out_num);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.done !== 1'b0) $display("FAIL one_shot_done_pulse: got %b want 0", bus.done);
        else pass_cnt++;
    endtask

    task automatic test_loop();
        int exp_num [12];
        exp_num = '{0, 0, 1, 1, 2, 3, 3, 3, 0, 1, 1, 2};
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk_cnt++;
            if (bus.out_num !== 3'(exp_num[i]) || bus.done !== 1'b0 || bus.busy !== 1'b1)
                $display("FAIL loop_c%0d: num=%0d done=%b busy=%b want num=%0d done=0 busy=1",
                         i + 1, bus.out_num, bus.done, bus.busy, exp_num[i]);
            else pass_cnt++;
            if (i == 11) bus.mode = 1'b0;
            step();
        end
        step();
        chk_cnt++;
        if (bus.busy !== 1'b1 || bus.out !== 2'd0)
            $display("FAIL loop_c14: busy=%b out=%0d want busy=1 out=0", bus.busy, bus.out);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1)
            $display("FAIL loop_exit: busy=%b done=%b want busy=0 done=1", bus.busy, bus.done);
        else pass_cnt++;
        step();
    endtask

    task automatic test_hold();
        int exp_out [12];
        exp_out = '{1, 3, 3, 3, 3, 3, 3, 3, 2, 0, 0, 0};
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk_cnt++;
            if (bus.out !== 2'(exp_out[i]) || bus.done !== 1'b0)
                $display("FAIL hold_c%0d: out=%0d done=%b want out=%0d done=0",
                         i + 1, bus.out, bus.done, exp_out[i]);
            else pass_cnt++;
            bus.hold = (i >= 1 && i <= 5);
            step();
        end
        bus.hold = 1'b0;
        chk_cnt++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL hold_end: done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
        else pass_cnt++;
        step();
    endtask

    task automatic test_cfg_in_run();
        int exp_out [7];
        exp_out = '{1, 3, 3, 2, 0, 0, 0};
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk_cnt++;
            if (bus.out !== 2'(exp_out[i]))
                $display("FAIL cfg_run_c%0d: out=%0d want %0d", i + 1, bus.out, exp_out[i]);
            else pass_cnt++;
            bus.cfg_we    = (i == 1);
            bus.cfg_addr  = 2'd0;
            bus.cfg_out   = 2'd2;
            bus.cfg_dwell = 4'd3;
            bus.start     = (i == 2);
            step();
        end
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        step();
        chk_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL start_in_run_ignored: busy=%b want 0", bus.busy);
        else pass_cnt++;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_cnt++;
        if (bus.out !== 2'd1) $display("FAIL cfg_run_entry0_out: got %0d want 1", bus.out);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.out !== 2'd3) $display("FAIL cfg_run_entry0_dwell: got %0d want 3", bus.out);
        else pass_cnt++;
        repeat (7) step();
    endtask

    task automatic test_write_with_start();
        bus.mode      = 1'b0;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'd0;
        bus.cfg_out   = 2'd2;
        bus.cfg_dwell = 4'd1;
        bus.start     = 1'b1;
        step();
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        chk_cnt++;
        if (bus.out !== 2'd2) $display("FAIL wr_start_c1: got %0d want 2", bus.out);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.out !== 2'd2) $display("FAIL wr_start_c2: got %0d want 2", bus.out);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.out !== 2'd3) $display("FAIL wr_start_c3: got %0d want 3", bus.out);
        else pass_cnt++;
        repeat (8) step();
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL wr_start_end: busy=%b want 0", bus.busy);
        else pass_cnt++;
        prog(0, 1, 0);
    endtask

`ifdef SWITCH_CASE_SEQ_ABORT_EN
    task automatic test_abort();
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk_cnt++;
        if (bus.out !== 2'd2) $display("FAIL abort_pre: out=%0d want 2", bus.out);
        else pass_cnt++;
        bus.abort = 1'b1;
        bus.hold  = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.hold  = 1'b0;
        chk_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 2'd0)
            $display("FAIL abort_exit: busy=%b done=%b out=%0d want 0 0 0",
                     bus.busy, bus.done, bus.out);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", bus.done);
        else pass_cnt++;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk_cnt++;
        if (bus.out !== 2'd1) $display("FAIL abort_table_kept: out=%0d want 1", bus.out);
        else pass_cnt++;
        repeat (8) step();
    endtask
`endif

    task automatic test_mid_reset();
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk_cnt++;
        if (bus.out !== 2'd0 || bus.out_num !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL mid_reset: out=%0d num=%0d busy=%b done=%b want all 0",
                     bus.out, bus.out_num, bus.busy, bus.done);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        chk_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL mid_reset_after: done=%b busy=%b want 0 0", bus.done, bus.busy);
        else pass_cnt++;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (bus.out !== 2'd0 || bus.busy !== 1'b1)
                $display("FAIL cleared_table_c%0d: out=%0d busy=%b want out=0 busy=1",
                         i + 1, bus.out, bus.busy);
            else pass_cnt++;
            step();
        end
        chk_cnt++;
        if (bus.done !== 1'b1) $display("FAIL cleared_table_done: got %b want 1", bus.done);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        chk_cnt       = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mode      = 1'b0;
        bus.hold      = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_out   = '0;
        bus.cfg_dwell = '0;
`ifdef SWITCH_CASE_SEQ_ABORT_EN
        bus.abort     = 1'b0;
`endif
        test_reset();
        prog_default();
        test_one_shot();
        test_loop();
        test_hold();
        test_cfg_in_run();
        test_write_with_start();
`ifdef SWITCH_CASE_SEQ_ABORT_EN
        test_abort();
`endif
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
